// File: rtl/fp_norm_pack.sv
// Post-add normalise-and-pack stage of fp_add: left-normalises the mantissa sum and packs an IEEE-754 result.
// Define FP_NORM_FAST_EN for a single-cycle leading-zero-count + barrel-shift normaliser (default: one shift per clock).
module fp_norm_pack #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAN_W-1:0]         sum,
  input  logic                     cout,
  input  logic                     signbit,
  input  logic [EXP_W-1:0]         exp_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W-1:0]   result,
  output logic                     zero,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned RES_W = EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX    = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAX_M1 = {{(EXP_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t            state_q, state_d;
  logic [MAN_W-1:0]  man_q, man_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              is_ovf_q, is_ovf_d;
  logic              is_zero_q, is_zero_d;
  logic              is_unf_q, is_unf_d;
  logic              in_ready_d, out_valid_d;
  logic [RES_W-1:0]  result_d;
  logic              zero_d, overflow_d, underflow_d;
  logic [RES_W-1:0]  packed_c;

`ifdef FP_NORM_FAST_EN
  localparam int unsigned LZ_W = $clog2(MAN_W + 1);

  function automatic logic [LZ_W-1:0] lzc(input logic [MAN_W-1:0] v);
    lzc = LZ_W'(MAN_W);
    for (int i = 0; i < int'(MAN_W); i++)
      if (v[i]) lzc = LZ_W'(int'(MAN_W) - 1 - i);
  endfunction

  logic [LZ_W-1:0]  lz_c;
  logic [EXP_W-1:0] limit_c;
  // Shifting may consume the exponent down to 1 and no further.
  assign lz_c    = lzc(man_q);
  assign limit_c = (exp_q == '0) ? '0 : exp_q - EXP_W'(1);
`endif

  // Final field selection; flags take priority over the normal encoding.
  always_comb begin
    if (is_ovf_q)       packed_c = {sign_q, EXP_MAX, {(MAN_W-1){1'b0}}};
    else if (is_zero_q) packed_c = '0;
    else if (is_unf_q)  packed_c = {sign_q, {(RES_W-1){1'b0}}};
    else                packed_c = {sign_q, exp_q, man_q[MAN_W-2:0]};
  end

  always_comb begin
    state_d     = state_q;
    man_d       = man_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    is_ovf_d    = is_ovf_q;
    is_zero_d   = is_zero_q;
    is_unf_d    = is_unf_q;
    out_valid_d = out_valid;
    result_d    = result;
    zero_d      = zero;
    overflow_d  = overflow;
    underflow_d = underflow;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d    = signbit;
          is_zero_d = 1'b0;
          is_unf_d  = 1'b0;
          is_ovf_d  = (cout && (exp_in >= EXP_MAX_M1)) || (exp_in == EXP_MAX);
          if (cout) begin
            man_d = {1'b1, sum[MAN_W-1:1]};
            exp_d = exp_in + EXP_W'(1);
          end else begin
            man_d = sum;
            exp_d = exp_in;
          end
          state_d = NORM;
        end
      end

      NORM: begin
        if (is_ovf_q) begin
          state_d = DONE;
        end else if (man_q == '0) begin
          is_zero_d = 1'b1;
          sign_d    = 1'b0;
          state_d   = DONE;
        end else begin
`ifdef FP_NORM_FAST_EN
          if (32'(lz_c) > 32'(limit_c)) begin
            is_unf_d = 1'b1;
          end else begin
            man_d = man_q << lz_c;
            exp_d = exp_q - EXP_W'(lz_c);
          end
          state_d = DONE;
`else
          if (man_q[MAN_W-1]) begin
            state_d = DONE;
          end else if (exp_q <= EXP_W'(1)) begin
            is_unf_d = 1'b1;
            state_d  = DONE;
          end else begin
            man_d = man_q << 1;
            exp_d = exp_q - EXP_W'(1);
          end
`endif
        end
      end

      DONE: begin
        // First DONE cycle registers the packed word; then hold until taken.
        if (!out_valid) begin
          out_valid_d = 1'b1;
          result_d    = packed_c;
          zero_d      = is_zero_q;
          overflow_d  = is_ovf_q;
          underflow_d = is_unf_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          zero_d      = 1'b0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      man_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      is_ovf_q  <= 1'b0;
      is_zero_q <= 1'b0;
      is_unf_q  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      man_q     <= man_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      is_ovf_q  <= is_ovf_d;
      is_zero_q <= is_zero_d;
      is_unf_q  <= is_unf_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      result    <= result_d;
      zero      <= zero_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Bench for fp_norm_pack: directed corner cases, hold/reset behaviour and randomized ops vs. an arithmetic model.
module tb_fp_norm_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] sum = '0;
  logic        cout = 1'b0;
  logic        signbit = 1'b0;
  logic [7:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, overflow, underflow;

  int checks = 0;
  int failures = 0;

  fp_norm_pack #(.EXP_W(8), .MAN_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .signbit(signbit), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference: value semantics of the stage; flags returned as {overflow, underflow, zero}.
  function automatic void model(input logic [23:0] s, input logic c, input logic sg,
                                input logic [7:0] e, output logic [31:0] r,
                                output logic [2:0] f, output int n);
    int mag, ex, man, msb, lz, room;
    n   = 0;
    mag = (c ? (1 << 24) : 0) + int'(s);
    if ((c && e >= 8'd254) || e == 8'd255) begin
      r = {sg, 8'hFF, 23'h0}; f = 3'b100; return;
    end
    if (mag == 0) begin
      r = 32'h0; f = 3'b001; return;
    end
    ex  = c ? int'(e) + 1 : int'(e);
    man = c ? mag / 2 : mag;
    msb = 0;
    for (int i = 0; i < 24; i++) if ((man >> i) & 1) msb = i;
    lz   = 23 - msb;
    room = (ex > 0) ? ex - 1 : 0;
    if (lz > room) begin
      n = room; r = {sg, 31'h0}; f = 3'b010;
    end else begin
      n = lz; ex = ex - lz; man = man * (1 << lz);
      r = {sg, 8'(ex), 23'(man)}; f = 3'b000;
    end
  endfunction

  function automatic int exp_lat(input int n);
`ifdef FP_NORM_FAST_EN
    exp_lat = 2 + 0 * n;
`else
    exp_lat = n + 2;
`endif
  endfunction

  task automatic start_op(input logic [23:0] s, input logic c, input logic sg, input logic [7:0] e);
    int guard = 0;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    sum = s; cout = c; signbit = sg; exp_in = e; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++; $display("FAIL reset_hs got=%b exp=10", {in_ready, out_valid});
    end
    checks++;
    if ({result, zero, overflow, underflow} !== 35'h0) begin
      failures++; $display("FAIL reset_out got=%h exp=0", {result, zero, overflow, underflow});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [23:0] s_t [4] = '{24'h000000, 24'h000001, 24'h400000, 24'h000100};
    logic        c_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        g_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  e_t [4] = '{8'd127, 8'd127, 8'd254, 8'd5};
    logic [31:0] r_t [4] = '{32'h40000000, 32'h34000000, 32'hFF800000, 32'h80000000};
    logic [2:0]  f_t [4] = '{3'b000, 3'b000, 3'b100, 3'b010};
    int          n_t [4] = '{0, 23, 0, 4};
    int lat;
    for (int k = 0; k < 4; k++) begin
      start_op(s_t[k], c_t[k], g_t[k], e_t[k]);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL dir%0d_busy in_ready=%b exp=0", k, in_ready);
      end
      wait_valid(lat);
      checks++;
      if (lat !== exp_lat(n_t[k])) begin
        failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", k, lat, exp_lat(n_t[k]));
      end
      checks++;
      if (result !== r_t[k]) begin
        failures++; $display("FAIL dir%0d_result got=%h exp=%h", k, result, r_t[k]);
      end
      checks++;
      if ({overflow, underflow, zero} !== f_t[k]) begin
        failures++; $display("FAIL dir%0d_flags got=%b exp=%b", k, {overflow, underflow, zero}, f_t[k]);
      end
      finish_op();
    end
  endtask

  task automatic test_zero_hold();
    int lat;
    start_op(24'h0, 1'b0, 1'b1, 8'd100);
    wait_valid(lat);
    checks++;
    if ({result, zero} !== {32'h0, 1'b1}) begin
      failures++; $display("FAIL zero_result got=%h/%b exp=0/1", result, zero);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({result, out_valid, in_ready, zero} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
        failures++; $display("FAIL zero_hold%0d got=%h/%b%b%b exp=0/101", k, result, out_valid, in_ready, zero);
      end
    end
    finish_op();
    checks++;
    if ({out_valid, in_ready, zero, overflow, underflow} !== 5'b01000) begin
      failures++; $display("FAIL zero_release got=%b exp=01000", {out_valid, in_ready, zero, overflow, underflow});
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    start_op(24'h000001, 1'b0, 1'b0, 8'd127);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL midop_reset got=%b exp=01", {out_valid, in_ready});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(24'h0, 1'b1, 1'b0, 8'd127);
    wait_valid(lat);
    checks++;
    if ({result, lat} !== {32'h40000000, 32'd2}) begin
      failures++; $display("FAIL midop_after got=%h lat=%0d exp=40000000 lat=2", result, lat);
    end
    finish_op();
  endtask

  task automatic test_random();
    logic [23:0] s;
    logic        c, g;
    logic [7:0]  e;
    logic [31:0] r;
    logic [2:0]  f;
    int n, lat, bad;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      s = 24'($urandom) >> $urandom_range(0, 24);
      c = ($urandom_range(0, 3) == 0);
      g = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom_range(0, 8));
        1:       e = 8'($urandom_range(250, 255));
        default: e = 8'($urandom);
      endcase
      model(s, c, g, e, r, f, n);
      start_op(s, c, g, e);
      wait_valid(lat);
      checks++;
      if (lat !== exp_lat(n) || result !== r || {overflow, underflow, zero} !== f) begin
        failures++; bad++;
        if (bad <= 10)
          $display("FAIL rand%0d in=%b_%h e=%0d got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                   k, c, s, e, result, {overflow, underflow, zero}, lat, r, f, exp_lat(n));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      finish_op();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_zero_hold();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
